// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timer
//  Purpose  : Memory-mapped 16-bit interval timer for the 6502 CPU bus.
//             Down-counter with 8-bit prescaler, auto-reload or one-shot
//             mode, sticky timer flag and level interrupt output.
//  Ports    : clk        - CPU clock, all logic on posedge
//             reset      - synchronous active-high reset
//             cs         - chip select for the 8-byte register window
//             addr[2:0]  - register offset
//             we         - write enable, qualified by cs
//             di[7:0]    - write data
//             dout[7:0]  - registered read data
//             dout_valid - high the cycle after a read access
//             irq        - level interrupt, TF & IE
//  Revision : 1.0 - initial release
// ============================================================================
module bus_timer #(
    parameter logic [7:0] RESET_PRESCALE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic       we,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       irq
);

    localparam logic [2:0] c_ADDR_CTRL     = 3'd0;
    localparam logic [2:0] c_ADDR_STATUS   = 3'd1;
    localparam logic [2:0] c_ADDR_RELOAD_L = 3'd2;
    localparam logic [2:0] c_ADDR_RELOAD_H = 3'd3;
    localparam logic [2:0] c_ADDR_COUNT_L  = 3'd4;
    localparam logic [2:0] c_ADDR_COUNT_H  = 3'd5;
    localparam logic [2:0] c_ADDR_PRESCALE = 3'd6;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        tf_q, tf_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  snap_q, snap_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;

    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_underflow;
    logic [7:0]  w_rdata;

    assign w_wr        = cs & we;
    assign w_rd        = cs & ~we;
    assign w_tick      = en_q & (psc_q == p_q);
    assign w_underflow = w_tick & (count_q == 16'd0);

    // Read data mux, sampled into dout on the access edge
    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            c_ADDR_CTRL:     w_rdata = {5'b0, ie_q, auto_q, en_q};
            c_ADDR_STATUS:   w_rdata = {7'b0, tf_q};
            c_ADDR_RELOAD_L: w_rdata = reload_q[7:0];
            c_ADDR_RELOAD_H: w_rdata = reload_q[15:8];
            c_ADDR_COUNT_L:  w_rdata = count_q[7:0];
            c_ADDR_COUNT_H:  w_rdata = snap_q;
            c_ADDR_PRESCALE: w_rdata = p_q;
            default:         w_rdata = 8'h00;
        endcase
    end

    always_comb begin
        en_d         = en_q;
        auto_d       = auto_q;
        ie_d         = ie_q;
        tf_d         = tf_q;
        reload_d     = reload_q;
        count_d      = count_q;
        snap_d       = snap_q;
        psc_d        = psc_q;
        p_d          = p_q;
        dout_d       = dout_q;
        dout_valid_d = w_rd;

        // Prescaler: held at 0 when disabled, wraps to 0 on a tick, and is
        // restarted by RELOAD_HI / PRESCALE writes.
        if (!en_q || w_tick) begin
            psc_d = 8'd0;
        end else if (w_wr && (addr == c_ADDR_RELOAD_H || addr == c_ADDR_PRESCALE)) begin
            psc_d = 8'd0;
        end else begin
            psc_d = psc_q + 8'd1;
        end

        // Counter: underflow is handled explicitly so the decrement never wraps
        if (w_tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                en_d = 1'b0;
            end
        end

        // Clear first so a same-cycle underflow wins the set
        if (w_wr && addr == c_ADDR_STATUS && di[0]) begin
            tf_d = 1'b0;
        end
        if (w_underflow) begin
            tf_d = 1'b1;
        end

        // Register writes are applied last so they override the tick effects
        // (written EN beats one-shot disable, RELOAD_HI load beats decrement).
        if (w_wr) begin
            case (addr)
                c_ADDR_CTRL: begin
                    en_d   = di[0];
                    auto_d = di[1];
                    ie_d   = di[2];
                end
                c_ADDR_RELOAD_L: reload_d[7:0] = di;
                c_ADDR_RELOAD_H: begin
                    reload_d[15:8] = di;
                    count_d        = {di, reload_q[7:0]};
                end
                c_ADDR_PRESCALE: p_d = di;
                default: ;
            endcase
        end

        if (w_rd) begin
            dout_d = w_rdata;
            // COUNT_LO read freezes the high byte so a 2-byte read is coherent
            if (addr == c_ADDR_COUNT_L) begin
                snap_d = count_q[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            auto_q       <= 1'b0;
            ie_q         <= 1'b0;
            tf_q         <= 1'b0;
            reload_q     <= 16'd0;
            count_q      <= 16'd0;
            snap_q       <= 8'd0;
            psc_q        <= 8'd0;
            p_q          <= RESET_PRESCALE;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            auto_q       <= auto_d;
            ie_q         <= ie_d;
            tf_q         <= tf_d;
            reload_q     <= reload_d;
            count_q      <= count_d;
            snap_q       <= snap_d;
            psc_q        <= psc_d;
            p_q          <= p_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign irq        = tf_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_timer
//  Purpose  : Self-checking bench for bus_timer. Read expectations are queued
//             by the stimulus and consumed by a monitor on dout_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

    localparam logic [7:0] c_RST_P = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       we = 1'b0;
    logic [7:0] di = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_q[$];   // {addr, expected data}

    bus_timer #(.RESET_PRESCALE(c_RST_P)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .addr       (addr),
        .we         (we),
        .di         (di),
        .dout       (dout),
        .dout_valid (dout_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on negedge; the access happens on the following posedge
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; di = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e);
        exp_q.push_back({a, e});
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every dout_valid must match the oldest queued read
    always @(negedge clk) begin
        if (!reset && dout_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got dout=%h with no read pending", dout);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (dout != e[7:0]) begin
                    n_bad++;
                    $display("FAIL rd_off%0d: got %h expected %h", e[10:8], dout, e[7:0]);
                end
            end
        end
    end

    initial begin
        idle(3);
        // Reset state
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_irq", int'(irq), 0);
        reset = 1'b0;
        idle(1);

        // 1: all registers read zero; writes never raise dout_valid
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), (i == 6) ? c_RST_P : 8'h00);
        end
        idle(1);
        wr(3'd7, 8'hA5);
        chk("valid_after_wr", int'(dout_valid), 0);
        rd(3'd7, 8'h00);
        wr(3'd5, 8'h12);
        chk("valid_after_wr2", int'(dout_valid), 0);

        // 2: auto mode, period 4
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h07);
        idle(3);
        chk("auto_irq_pre", int'(irq), 0);
        idle(1);
        chk("auto_irq_1", int'(irq), 1);
        // 4: plain W1C clear
        wr(3'd1, 8'h01);
        chk("w1c_clear", int'(irq), 0);
        idle(2);
        chk("auto_irq_pre2", int'(irq), 0);
        idle(1);
        chk("auto_irq_2", int'(irq), 1);
        // 4: clear landing on the underflow edge, set wins
        idle(3);
        wr(3'd1, 8'h01);
        chk("w1c_vs_underflow", int'(irq), 1);
        wr(3'd1, 8'h01);
        chk("w1c_clear2", int'(irq), 0);
        wr(3'd0, 8'h00);

        // 3: one-shot, 12 clocks
        wr(3'd6, 8'h03);
        wr(3'd2, 8'h02);
        wr(3'd3, 8'h00);
        wr(3'd1, 8'h01);
        wr(3'd0, 8'h05);
        idle(11);
        chk("oneshot_irq_pre", int'(irq), 0);
        idle(1);
        chk("oneshot_irq", int'(irq), 1);
        rd(3'd0, 8'h04);
        rd(3'd4, 8'h00);
        rd(3'd5, 8'h00);
        idle(10);
        rd(3'd4, 8'h00);
        rd(3'd1, 8'h01);

        // CTRL write on a one-shot underflow edge: written EN survives
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h01);
        wr(3'd6, 8'h01);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h01);
        idle(1);
        wr(3'd0, 8'h01);
        rd(3'd0, 8'h01);
        rd(3'd1, 8'h01);
        wr(3'd0, 8'h00);

        // 5: COUNT_HI snapshot
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        wr(3'd0, 8'h03);
        rd(3'd4, 8'h00);
        idle(2);
        rd(3'd5, 8'h01);

        // 6: reset mid-count with irq asserted
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h07);
        for (int i = 0; i < 50 && !irq; i++) @(negedge clk);
        chk("pre_reset_irq", int'(irq), 1);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("post_reset_irq", int'(irq), 0);
        chk("post_reset_valid", int'(dout_valid), 0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), (i == 6) ? c_RST_P : 8'h00);
        end
        idle(6);
        rd(3'd4, 8'h00);
        rd(3'd1, 8'h00);
        chk("post_reset_irq2", int'(irq), 0);
        idle(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit interval timer on the 6502 CPU bus. It is a neighbour of the internal ROM/RAM/LED decode and drives the CPU `IRQ` input, which is currently tied low.
- The system decodes an 8-byte window and drives `cs`. The block returns read data registered one cycle after the access, with the same timing as internal RAM/ROM.
- Provides periodic or one-shot interrupts for firmware timing: LED blink rate, delays.

Parameters:
- RESET_PRESCALE, 8'h00, PRESCALE register value after reset.

Ports:
- clk  input  1  CPU clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select, active high; window decoded by the system.
- addr  input  3  register offset (CPU address bits [2:0]).
- we  input  1  write enable, active high; qualified by cs.
- di  input  8  write data from CPU data-out bus.
- dout  output  8  registered read data.
- dout_valid  output  1  high for the one cycle after a cs & !we access; system muxes dout onto CPU DI when set.
- irq  output  1  level interrupt, active high.

Behaviour:
- Register map (offset: name):
  - 0: CTRL. bit0 EN, bit1 AUTO, bit2 IE; bits[7:3] read 0.
  - 1: STATUS. bit0 TF; write 1 to bit0 clears TF; other bits read 0, write ignored.
  - 2: RELOAD_LO.
  - 3: RELOAD_HI. Write also loads count <= {di, RELOAD_LO} and clears the prescaler.
  - 4: COUNT_LO. Read returns count[7:0] and captures count[15:8] into a snapshot on the same edge.
  - 5: COUNT_HI. Read returns the snapshot; write ignored.
  - 6: PRESCALE (P). Write clears the prescaler.
  - 7: reserved; reads 0x00, writes ignored.
- Reset (synchronous): CTRL, STATUS, RELOAD, count, snapshot and prescaler = 0; PRESCALE = RESET_PRESCALE; dout = 0x00; dout_valid = 0; irq = 0. A reset mid-count aborts the count; the next cycle shows reset state.
- Prescaler:
  - While EN=1, counts 0..P. A tick occurs on the cycle where prescaler == P, and the prescaler returns to 0.
  - While EN=0, the prescaler is held at 0 and count holds its value.
- On tick:
  - If count != 0: count <= count - 1.
  - If count == 0 (underflow): TF <= 1. If AUTO=1, count <= RELOAD. If AUTO=0 (one-shot), EN <= 0 and count stays 0.
- Period in AUTO mode is (RELOAD+1)*(P+1) clocks. RELOAD=0 with P=0 underflows every clock.
- irq = TF & IE, decoded from flops with no added latency. Clearing IE masks irq but keeps TF.
- Read timing:
  - When cs & !we at edge N, dout holds register data sampled at edge N and dout_valid=1 during cycle N+1.
  - Otherwise dout_valid <= 0 and dout holds its last value.
  - Writes never assert dout_valid.
- Simultaneous events:
  - Underflow and a TF-clear write in the same cycle: TF stays 1 (set wins).
  - RELOAD_HI write and a tick in the same cycle: the load wins; no decrement.
  - CTRL write and a one-shot underflow in the same cycle: the written EN wins; TF is still set.
  - PRESCALE write and a tick in the same cycle: the tick takes effect and the prescaler goes to 0.
- Width rules: count and RELOAD are 16-bit unsigned; decrement never wraps because underflow is handled explicitly.

Test Plan:
1. Reset, then read offsets 0..7 -> every dout = 0x00; dout_valid high exactly one cycle after each read, low after writes.
2. Write PRESCALE=0x00, RELOAD_LO=0x03, RELOAD_HI=0x00, CTRL=0x07 -> TF/irq rise on the 4th clock after the CTRL write edge, and again every 4 clocks thereafter after each TF clear.
3. One-shot: PRESCALE=0x03, RELOAD=0x0002, CTRL=0x05 -> TF=1 and irq=1 after 12 clocks; CTRL reads 0x04; COUNT reads 0x0000 and stays there.
4. W1C: with TF=1 write STATUS=0x01 -> TF=0, irq=0 next cycle. Repeat with the write landing on the underflow cycle -> TF remains 1.
5. Snapshot: RELOAD=0x0100, EN=1, AUTO=1, P=0. Read COUNT_LO when count=0x0100 -> 0x00. After one or more ticks, read COUNT_HI -> 0x01 (snapshot, not the live 0x00).
6. Reset asserted mid-count with irq=1 -> next cycle irq=0 and all registers read 0x00 (PRESCALE = RESET_PRESCALE); the counter does not restart until reprogrammed.
